// File: rtl/mont_mul_serial.sv
// rtl/mont_mul_serial.sv - bit-serial radix-2 Montgomery multiplier, R = A*B*2^-N mod M
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   A, B, M              operands and odd modulus, latched when a request is accepted
//   req_valid            request strobe, honoured only while idle
//   req_ready            one-cycle acknowledge of the accepted request
//   req_busy             high from accept until the result is written
//   R, res_valid         result and its valid flag, both held until res_ready
//   res_ready            consumer takes the result
module mont_mul_serial #(
    parameter int N = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] M,
    input  logic         req_valid,
    output logic         req_ready,
    output logic         req_busy,
    output logic [N-1:0] R,
    output logic         res_valid,
    input  logic         res_ready
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_LOOP,
        S_FINAL,
        S_POST
    } state_t;

    state_t state, state_nx;

    logic [N-1:0]  ar;      // multiplicand, shifted right so bit 0 is the current digit
    logic [N-1:0]  br;
    logic [N-1:0]  mr;
    logic [N:0]    s;       // partial result, always below 2*mr
    logic [CW-1:0] cnt;

    logic [N+1:0]  t;
    logic [N:0]    s_nx;
    logic          s_ge;
    logic [N-1:0]  s_sub;
    logic          last_iter;

    always_comb begin
        t = {1'b0, s} + (ar[0] ? {2'b00, br} : '0);
        // (t + mr) / 2 for odd t is (t >> 1) + (mr >> 1) + 1 when mr is odd;
        // writing it this way drops the always-zero LSB of the sum.
        s_nx = t[N+1:1] + (t[0] ? {2'b00, mr[N-1:1]} : '0) + {{N{1'b0}}, t[0]};
        s_ge = (s >= {1'b0, mr});
        // Only used when s >= mr, where the difference is below mr and fits N bits.
        s_sub = s[N-1:0] - mr;
        last_iter = (cnt == CW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (req_valid) state_nx = S_READY;
            S_READY: state_nx = S_LOOP;
            S_LOOP:  if (last_iter) state_nx = S_FINAL;
            S_FINAL: state_nx = S_POST;
            S_POST:  if (res_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar        <= '0;
            br        <= '0;
            mr        <= '0;
            s         <= '0;
            cnt       <= '0;
            R         <= '0;
            req_ready <= 1'b0;
            req_busy  <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        ar        <= A;
                        br        <= B;
                        mr        <= M;
                        req_ready <= 1'b1;
                        req_busy  <= 1'b1;
                    end
                end
                S_READY: begin
                    req_ready <= 1'b0;
                    s         <= '0;
                    cnt       <= '0;
                end
                S_LOOP: begin
                    s   <= s_nx;
                    ar  <= ar >> 1;
                    cnt <= cnt + CW'(1);
                end
                S_FINAL: begin
                    R         <= s_ge ? s_sub : s[N-1:0];
                    res_valid <= 1'b1;
                    req_busy  <= 1'b0;
                end
                S_POST: begin
                    if (res_ready) res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_mul_serial.sv
// tb/tb_mont_mul_serial.sv - self-checking bench for mont_mul_serial against a modular-arithmetic model
module tb_mont_mul_serial;

    localparam int N = 255;
    localparam int W = 2 * N + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic [N-1:0] M = '0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_busy;
    logic [N-1:0] R;
    logic         res_valid;
    logic         res_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [N-1:0] P;
    assign P = {N{1'b1}} - N'(18);

    mont_mul_serial #(.N(N)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .M         (M),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_busy  (req_busy),
        .R         (R),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    always #5 clk = ~clk;

    // a*b*2^-n mod m: reduce the product, then halve modulo m n times.
    function automatic logic [N-1:0] golden(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [N-1:0] m, input int n);
        logic [W-1:0] r, mm, aa, bb;
        aa = W'(a);
        bb = W'(b);
        mm = W'(m);
        r = (aa * bb) % mm;
        for (int i = 0; i < n; i++) begin
            if (r[0]) r = (r + mm) >> 1;
            else      r = r >> 1;
        end
        return r[N-1:0];
    endfunction

    function automatic logic [N-1:0] rand_below_p();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v = (v << 32) | N'($urandom);
        if (v >= P) v = v - P;
        return v;
    endfunction

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0b, expected %0b at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural model: edges since accept, result-valid flag, expected R.
    int           mk = -1;
    logic         mvalid = 1'b0;
    logic [N-1:0] m_exp = '0;
    logic [N-1:0] m_r = '0;
    int           ndone = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mk = -1;
            mvalid = 1'b0;
            m_r = '0;
        end else if (mk >= 0) begin
            mk++;
            if (mk == N + 2) begin
                mvalid = 1'b1;
                m_r = m_exp;
                mk = -1;
            end
        end else if (mvalid) begin
            if (res_ready) begin
                mvalid = 1'b0;
                ndone++;
            end
        end else if (req_valid) begin
            m_exp = golden(A, B, M, N);
            mk = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check_bit("req_ready", req_ready, mk == 0);
            check_bit("req_busy", req_busy, mk >= 0);
            check_bit("res_valid", res_valid, mvalid);
            check("R", R, m_r);
        end
    end

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] m,
                          input logic [N-1:0] expect_r, input string name);
        int edges;
        @(negedge clk);
        A = a; B = b; M = m; req_valid = 1'b1; res_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        A = '1; B = '1; M = '1;
        edges = 0;
        while (!res_valid && edges < N + 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({name, "_latency"}, N'(edges), N'(N + 2));
        check({name, "_r"}, R, expect_r);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_bit({name, "_released"}, res_valid, 1'b0);
    endtask

    initial begin
        int cnt_ready;
        logic [N-1:0] ra, rb;

        repeat (3) @(negedge clk);
        check_bit("rst_req_ready", req_ready, 1'b0);
        check_bit("rst_req_busy", req_busy, 1'b0);
        check_bit("rst_res_valid", res_valid, 1'b0);
        check("rst_R", R, '0);
        rst_n = 1'b1;

        check("model_n8_5x7", golden(N'(5), N'(7), N'(13), 8), N'(1));
        check("model_n8_11x1", golden(N'(11), N'(1), N'(13), 8), N'(7));
        check("model_n8_12x12", golden(N'(12), N'(12), N'(13), 8), N'(3));
        check("model_n255_5x7", golden(N'(5), N'(7), N'(13), 255), N'(6));

        // With N=255 and M=13, 2^-255 mod 13 = 5.
        run_op(N'(5), N'(7), N'(13), N'(6), "m13_5x7");
        run_op(N'(11), N'(1), N'(13), N'(3), "m13_11x1");
        run_op(N'(0), N'(9), N'(13), N'(0), "m13_0x9");
        run_op(N'(12), N'(12), N'(13), N'(5), "m13_12x12");

        // Asynchronous reset in the middle of the loop.
        @(negedge clk);
        A = rand_below_p(); B = rand_below_p(); M = P; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (101) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_bit("midrst_req_busy", req_busy, 1'b0);
        check_bit("midrst_res_valid", res_valid, 1'b0);
        check_bit("midrst_req_ready", req_ready, 1'b0);
        check("midrst_R", R, '0);
        @(negedge clk);
        rst_n = 1'b1;
        ra = rand_below_p();
        rb = rand_below_p();
        run_op(ra, rb, P, golden(ra, rb, P, N), "after_rst");

        // Back-to-back requests: one accept every N+4 cycles.
        @(negedge clk);
        M = P; A = rand_below_p(); B = rand_below_p();
        res_ready = 1'b1; req_valid = 1'b1;
        @(posedge clk);
        cnt_ready = 0;
        repeat (3 * (N + 4)) begin
            @(negedge clk);
            if (req_ready) cnt_ready++;
        end
        req_valid = 1'b0;
        check("throughput_accepts", N'(cnt_ready), N'(3));
        repeat (N + 10) @(negedge clk);

        // Random traffic: inputs change every cycle, req_valid toggles while busy,
        // res_ready stalls randomly.
        ndone = 0;
        for (int i = 0; i < 50000; i++) begin
            @(negedge clk);
            A = rand_below_p();
            B = rand_below_p();
            M = P;
            req_valid = ($urandom_range(0, 3) != 0);
            res_ready = ($urandom_range(0, 2) == 0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        res_ready = 1'b1;
        repeat (N + 10) @(negedge clk);
        check_bit("random_ops_completed", ndone >= 150, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
